// File: rtl/host_device_bus.sv
// Bus interconnect: fixed-priority arbitration among hosts, base/mask address decode to devices,
// and routing of the fixed one-cycle device response back to the granted host.
module host_device_bus #(
    parameter int unsigned NrDevices    = 1,
    parameter int unsigned NrHosts      = 1,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      host_req_i           [NrHosts],
    output logic                      host_gnt_o           [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i          [NrHosts],
    input  logic                      host_we_i            [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i            [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i         [NrHosts],
    output logic                      host_rvalid_o        [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o         [NrHosts],
    output logic                      host_err_o           [NrHosts],

    output logic                      device_req_o         [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o        [NrDevices],
    output logic                      device_we_o          [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o          [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o       [NrDevices],
    input  logic                      device_rvalid_i      [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i       [NrDevices],
    input  logic                      device_err_i         [NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int unsigned HostSelW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned DevSelW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic                    granted;
    logic [HostSelW-1:0]     host_sel_d, host_sel_q;
    logic                    hit;
    logic [DevSelW-1:0]      dev_sel_d, dev_sel_q;
    logic                    pending_q, err_q;

    logic [AddressWidth-1:0] win_addr;
    logic                    win_we;
    logic [DataWidth/8-1:0]  win_be;
    logic [DataWidth-1:0]    win_wdata;

    logic                    sel_rvalid;
    logic [DataWidth-1:0]    sel_rdata;
    logic                    sel_err;

    // Lowest-index requesting host wins; its fields are captured while scanning.
    always_comb begin
        granted    = 1'b0;
        host_sel_d = '0;
        win_addr   = '0;
        win_we     = 1'b0;
        win_be     = '0;
        win_wdata  = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (host_req_i[h] && !granted) begin
                granted    = 1'b1;
                host_sel_d = HostSelW'(h);
                win_addr   = host_addr_i[h];
                win_we     = host_we_i[h];
                win_be     = host_be_i[h];
                win_wdata  = host_wdata_i[h];
            end
        end
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = granted && (host_sel_d == HostSelW'(h));
        end
    end

    // Lowest-index matching device wins when address windows overlap.
    always_comb begin
        hit       = 1'b0;
        dev_sel_d = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (!hit && ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
                hit       = 1'b1;
                dev_sel_d = DevSelW'(d);
            end
        end
        for (int unsigned d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = granted && hit && (dev_sel_d == DevSelW'(d));
            device_addr_o[d]  = win_addr;
            device_we_o[d]    = win_we;
            device_be_o[d]    = win_be;
            device_wdata_o[d] = win_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q  <= 1'b0;
            host_sel_q <= '0;
            dev_sel_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            pending_q <= granted;
            if (granted) begin
                host_sel_q <= host_sel_d;
                dev_sel_q  <= dev_sel_d;
                err_q      <= !hit;
            end
        end
    end

    always_comb begin
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        sel_err    = 1'b0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (dev_sel_q == DevSelW'(d)) begin
                sel_rvalid = device_rvalid_i[d];
                sel_rdata  = device_rdata_i[d];
                sel_err    = device_err_i[d];
            end
        end
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = 1'b0;
            host_rdata_o[h]  = '0;
            host_err_o[h]    = 1'b0;
            if (pending_q && (host_sel_q == HostSelW'(h))) begin
                if (err_q) begin
                    // Unmapped address: synthesize the error response locally.
                    host_rvalid_o[h] = 1'b1;
                    host_err_o[h]    = 1'b1;
                end else begin
                    host_rvalid_o[h] = sel_rvalid;
                    host_rdata_o[h]  = sel_rdata;
                    host_err_o[h]    = sel_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_host_device_bus.sv
// Randomized bench for host_device_bus: two hosts, three devices, checked every cycle against
// a transaction-level reference model (winner, target device, one-cycle-delayed response).
module tb_host_device_bus;

    localparam int NH = 2;
    localparam int ND = 3;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          h_req    [NH];
    logic          h_gnt    [NH];
    logic [AW-1:0] h_addr   [NH];
    logic          h_we     [NH];
    logic [DW/8-1:0] h_be   [NH];
    logic [DW-1:0] h_wdata  [NH];
    logic          h_rvalid [NH];
    logic [DW-1:0] h_rdata  [NH];
    logic          h_err    [NH];

    logic          d_req    [ND];
    logic [AW-1:0] d_addr   [ND];
    logic          d_we     [ND];
    logic [DW/8-1:0] d_be   [ND];
    logic [DW-1:0] d_wdata  [ND];
    logic          d_rvalid [ND];
    logic [DW-1:0] d_rdata  [ND];
    logic          d_err    [ND];
    logic [AW-1:0] base     [ND];
    logic [AW-1:0] mask     [ND];

    host_device_bus #(
        .NrDevices   (ND),
        .NrHosts     (NH),
        .DataWidth   (DW),
        .AddressWidth(AW)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .host_req_i          (h_req),
        .host_gnt_o          (h_gnt),
        .host_addr_i         (h_addr),
        .host_we_i           (h_we),
        .host_be_i           (h_be),
        .host_wdata_i        (h_wdata),
        .host_rvalid_o       (h_rvalid),
        .host_rdata_o        (h_rdata),
        .host_err_o          (h_err),
        .device_req_o        (d_req),
        .device_addr_o       (d_addr),
        .device_we_o         (d_we),
        .device_be_o         (d_be),
        .device_wdata_o      (d_wdata),
        .device_rvalid_i     (d_rvalid),
        .device_rdata_i      (d_rdata),
        .device_err_i        (d_err),
        .cfg_device_addr_base(base),
        .cfg_device_addr_mask(mask)
    );

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Reference state: the transaction accepted last cycle (-1 device means unmapped).
    bit m_pending = 1'b0;
    int m_host    = 0;
    int m_dev     = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int target_of(input logic [AW-1:0] a);
        for (int d = 0; d < ND; d++) begin
            if ((a & mask[d]) == base[d]) return d;
        end
        return -1;
    endfunction

    task automatic set_map();
        base[0] = 32'h0010_0000; mask[0] = ~32'h000F_FFFF;
        base[1] = 32'h0002_0000; mask[1] = ~32'h0000_03FF;
        base[2] = 32'h0003_0000; mask[2] = ~32'h0000_03FF;
    endtask

    task automatic idle();
        for (int h = 0; h < NH; h++) begin
            h_req[h] = 1'b0; h_addr[h] = '0; h_we[h] = 1'b0; h_be[h] = '0; h_wdata[h] = '0;
        end
        for (int d = 0; d < ND; d++) begin
            d_rvalid[d] = 1'b0; d_rdata[d] = '0; d_err[d] = 1'b0;
        end
    endtask

    task automatic host_acc(input int h, input logic [AW-1:0] a, input logic we,
                            input logic [3:0] be, input logic [DW-1:0] wd);
        h_req[h] = 1'b1; h_addr[h] = a; h_we[h] = we; h_be[h] = be; h_wdata[h] = wd;
    endtask

    task automatic dev_resp(input int d, input logic [DW-1:0] rd, input logic err);
        d_rvalid[d] = 1'b1; d_rdata[d] = rd; d_err[d] = err;
    endtask

    // Called just after a falling edge with inputs applied; checks, then advances one cycle.
    task automatic step();
        int win;
        int tgt;
        logic [NH-1:0] got_gnt, exp_gnt, got_rv, exp_rv, got_er, exp_er;
        logic [ND-1:0] got_req, exp_req;
        logic [DW-1:0] exp_rd;
        #1;
        win = -1;
        for (int h = NH - 1; h >= 0; h--) if (h_req[h]) win = h;
        tgt = (win >= 0) ? target_of(h_addr[win]) : -1;
        for (int h = 0; h < NH; h++) begin
            got_gnt[h] = h_gnt[h];
            exp_gnt[h] = (h == win);
            got_rv[h]  = h_rvalid[h];
            got_er[h]  = h_err[h];
            exp_rv[h]  = 1'b0;
            exp_er[h]  = 1'b0;
            exp_rd     = '0;
            if (m_pending && h == m_host) begin
                if (m_dev < 0) begin
                    exp_rv[h] = 1'b1; exp_er[h] = 1'b1;
                end else begin
                    exp_rv[h] = d_rvalid[m_dev]; exp_er[h] = d_err[m_dev];
                    exp_rd = d_rdata[m_dev];
                end
            end
            check($sformatf("rdata[%0d]", h), 64'(h_rdata[h]), 64'(exp_rd));
        end
        for (int d = 0; d < ND; d++) begin
            got_req[d] = d_req[d];
            exp_req[d] = (win >= 0) && (d == tgt);
            if (win >= 0) begin
                check($sformatf("dev_addr[%0d]", d), 64'(d_addr[d]), 64'(h_addr[win]));
                check($sformatf("dev_fields[%0d]", d), {d_we[d], d_be[d], d_wdata[d]},
                      {h_we[win], h_be[win], h_wdata[win]});
            end
        end
        check("gnt", 64'(got_gnt), 64'(exp_gnt));
        check("dev_req", 64'(got_req), 64'(exp_req));
        check("rvalid", 64'(got_rv), 64'(exp_rv));
        check("err", 64'(got_er), 64'(exp_er));
        m_pending = rst_n && (win >= 0);
        m_host    = (win >= 0) ? win : 0;
        m_dev     = tgt;
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return 32'h0010_0000 | AW'($urandom_range(0, 32'hF_FFFF));
            1: return 32'h0002_0000 + AW'($urandom_range(0, 32'h3FF));
            2: return 32'h0003_0000 + AW'($urandom_range(0, 32'h3FF));
            3: return 32'h0004_0000 + AW'($urandom_range(0, 32'hFFFF));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        set_map();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Read from dev0
        host_acc(0, 32'h0010_0004, 1'b0, 4'hF, '0);
        step();
        idle(); dev_resp(0, 32'hDEAD_BEEF, 1'b0);
        #1 check("t1_rdata", 64'(h_rdata[0]), 64'h0000_0000_DEAD_BEEF);
        step();

        // Write to dev1
        host_acc(0, 32'h0002_0000, 1'b1, 4'h1, 32'h41);
        #1 check("t2_req1", 64'(d_req[1]), 64'd1);
        check("t2_wdata", 64'(d_wdata[1]), 64'h41);
        step();
        idle(); dev_resp(1, '0, 1'b0);
        #1 check("t2_rvalid", 64'(h_rvalid[0]), 64'd1);
        step();

        // Unmapped read; a stray device response must not leak through
        host_acc(0, 32'h0004_0000, 1'b0, 4'hF, '0);
        step();
        idle(); dev_resp(0, 32'h1234_5678, 1'b0);
        #1 check("t3_err", 64'(h_err[0]), 64'd1);
        check("t3_rdata", 64'(h_rdata[0]), 64'd0);
        step();

        // Back-to-back reads
        host_acc(0, 32'h0010_0000, 1'b0, 4'hF, '0);
        step();
        host_acc(0, 32'h0003_0000, 1'b0, 4'hF, '0); dev_resp(0, 32'hA0, 1'b0);
        step();
        host_acc(0, 32'h0010_0008, 1'b0, 4'hF, '0); dev_resp(0, 32'hBAD, 1'b0);
        dev_resp(2, 32'hA2, 1'b0);
        #1 check("t4_rdata2", 64'(h_rdata[0]), 64'hA2);
        step();
        idle(); dev_resp(0, 32'hA3, 1'b0);
        step();

        // Two hosts in the same cycle
        host_acc(0, 32'h0010_0000, 1'b0, 4'hF, '0);
        host_acc(1, 32'h0002_0004, 1'b0, 4'hF, '0);
        #1 check("t5_gnt1", 64'(h_gnt[1]), 64'd0);
        step();
        h_req[0] = 1'b0; dev_resp(0, 32'hC0, 1'b0);
        step();
        idle(); dev_resp(1, 32'hC1, 1'b0);
        #1 check("t5_rdata1", 64'(h_rdata[1]), 64'hC1);
        check("t5_rvalid0", 64'(h_rvalid[0]), 64'd0);
        step();

        // Reset drops an in-flight response
        host_acc(0, 32'h0010_0000, 1'b0, 4'hF, '0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; idle(); dev_resp(0, 32'hEE, 1'b0);
        #1 check("t6_drop", 64'(h_rvalid[0]), 64'd0);
        step();

        // Device error passes through with rvalid
        host_acc(0, 32'h0003_0010, 1'b0, 4'hF, '0);
        step();
        idle(); dev_resp(2, '0, 1'b1);
        #1 check("t6_err", 64'({h_rvalid[0], h_err[0]}), 64'b11);
        step();

        // Overlapping windows: lower index device takes the access
        base[2] = 32'h0002_0000;
        host_acc(1, 32'h0002_0010, 1'b0, 4'hF, '0);
        #1 check("ovl_req", 64'({d_req[2], d_req[1]}), 64'b01);
        step();
        idle(); set_map();
        step();

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            for (int h = 0; h < NH; h++) begin
                h_req[h]   = $urandom_range(0, 1);
                h_addr[h]  = rand_addr();
                h_we[h]    = $urandom_range(0, 1);
                h_be[h]    = 4'($urandom);
                h_wdata[h] = $urandom;
            end
            for (int d = 0; d < ND; d++) begin
                d_rvalid[d] = ($urandom_range(0, 3) != 0);
                d_rdata[d]  = $urandom;
                d_err[d]    = ($urandom_range(0, 7) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
